// File: rtl/free_list_n.sv
// Circular-buffer free list of physical-register tags: up to WAY grants and WAY frees per cycle.
// Optional head checkpoint/recovery is compiled in with `define FL_CHECKPOINT_EN.
module free_list_n #(
    parameter int TAG_W     = 7,
    parameter int NUM_AREGS = 32,
    parameter int DEPTH     = 64,
    parameter int WAY       = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [$clog2(WAY+1)-1:0]     dispatch_num,
    input  logic [$clog2(WAY+1)-1:0]     retire_num,
    input  logic [WAY*TAG_W-1:0]         retire_tags,
`ifdef FL_CHECKPOINT_EN
    input  logic                         ckpt_save,
    input  logic                         recover,
`endif
    output logic [WAY*TAG_W-1:0]         alloc_tags,
    output logic [WAY-1:0]               alloc_valid,
    output logic [$clog2(WAY+1)-1:0]     grant_num,
    output logic [$clog2(DEPTH):0]       free_count,
    output logic                         overflow_err
);

    localparam int CNT_W = $clog2(WAY+1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int OVF_W = PTR_W + 1;

    logic [TAG_W-1:0] entry_q [DEPTH];
    logic [TAG_W-1:0] entry_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             overflow_err_q, overflow_err_d;
    logic [PTR_W-1:0] count_s;
    logic [OVF_W-1:0] need_s;
    logic [PTR_W-1:0] next_cnt_s;
    logic             recover_s;
`ifdef FL_CHECKPOINT_EN
    logic [PTR_W-1:0] snap_q, snap_d;
    assign recover_s = recover;
`else
    assign recover_s = 1'b0;
`endif

    // The wrap bit makes tail - head distinguish full (DEPTH) from empty (0).
    assign count_s      = tail_q - head_q;
    assign free_count   = count_s;
    assign overflow_err = overflow_err_q;

    // Grant logic: oldest entries first, no forwarding of this cycle's frees.
    always_comb begin
        grant_num   = {CNT_W{1'b0}};
        alloc_tags  = {(WAY*TAG_W){1'b0}};
        alloc_valid = {WAY{1'b0}};
        if (recover_s) begin
            grant_num = {CNT_W{1'b0}};
        end else if (count_s < PTR_W'(dispatch_num)) begin
            grant_num = CNT_W'(count_s);
        end else begin
            grant_num = dispatch_num;
        end
        for (int k = 0; k < WAY; k++) begin
            if (CNT_W'(k) < grant_num) begin
                alloc_tags[k*TAG_W +: TAG_W] = entry_q[head_q[IDX_W-1:0] + IDX_W'(k)];
                alloc_valid[k]               = 1'b1;
            end else begin
                alloc_valid[k] = 1'b0;
            end
        end
    end

    // Next-state for storage, pointers, snapshot and the sticky overflow flag.
    always_comb begin
        entry_d = entry_q;
        for (int k = 0; k < WAY; k++) begin
            if (CNT_W'(k) < retire_num) begin
                entry_d[tail_q[IDX_W-1:0] + IDX_W'(k)] = retire_tags[k*TAG_W +: TAG_W];
            end else begin
                entry_d[tail_q[IDX_W-1:0] + IDX_W'(k)] = entry_q[tail_q[IDX_W-1:0] + IDX_W'(k)];
            end
        end
        tail_d = tail_q + PTR_W'(retire_num);
`ifdef FL_CHECKPOINT_EN
        if (recover_s) begin
            head_d = snap_q;
            snap_d = snap_q;
        end else if (ckpt_save) begin
            head_d = head_q + PTR_W'(grant_num);
            snap_d = head_q + PTR_W'(grant_num);
        end else begin
            head_d = head_q + PTR_W'(grant_num);
            snap_d = snap_q;
        end
`else
        head_d = head_q + PTR_W'(grant_num);
`endif
        next_cnt_s = tail_d - head_d;
        // Widened so an excess of up to WAY over DEPTH cannot alias back into range.
        need_s = OVF_W'(count_s) - OVF_W'(grant_num) + OVF_W'(retire_num);
        overflow_err_d = overflow_err_q;
        if (need_s > OVF_W'(DEPTH)) begin
            overflow_err_d = 1'b1;
        end else if (recover_s && (next_cnt_s > PTR_W'(DEPTH))) begin
            overflow_err_d = 1'b1;
        end else begin
            overflow_err_d = overflow_err_q;
        end
    end

    // State registers; reset fills the list with every non-architectural tag.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= TAG_W'(NUM_AREGS + i);
            end
            head_q         <= {PTR_W{1'b0}};
            tail_q         <= PTR_W'(DEPTH);
            overflow_err_q <= 1'b0;
`ifdef FL_CHECKPOINT_EN
            snap_q         <= {PTR_W{1'b0}};
`endif
        end else begin
            entry_q        <= entry_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            overflow_err_q <= overflow_err_d;
`ifdef FL_CHECKPOINT_EN
            snap_q         <= snap_d;
`endif
        end
    end

endmodule

// File: tb/tb_free_list_n.sv
// Directed self-checking bench for free_list_n in its default configuration (WAY=2, DEPTH=64).
module tb_free_list_n;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  dispatch_num;
    logic [1:0]  retire_num;
    logic [13:0] retire_tags;
    logic [13:0] alloc_tags;
    logic [1:0]  alloc_valid;
    logic [1:0]  grant_num;
    logic [6:0]  free_count;
    logic        overflow_err;
    int          total = 0;
    int          bad   = 0;

    free_list_n #(.TAG_W(7), .NUM_AREGS(32), .DEPTH(64), .WAY(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .dispatch_num (dispatch_num),
        .retire_num   (retire_num),
        .retire_tags  (retire_tags),
`ifdef FL_CHECKPOINT_EN
        .ckpt_save    (1'b0),
        .recover      (1'b0),
`endif
        .alloc_tags   (alloc_tags),
        .alloc_valid  (alloc_valid),
        .grant_num    (grant_num),
        .free_count   (free_count),
        .overflow_err (overflow_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] d, input logic [1:0] r, input logic [6:0] t0, input logic [6:0] t1);
        dispatch_num = d;
        retire_num   = r;
        retire_tags  = {t1, t0};
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(2'd0, 2'd0, 7'd0, 7'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        check("reset_free_count", 32'(free_count), 32'd64);
        check("reset_overflow", 32'(overflow_err), 32'd0);
        check("reset_grant_idle", 32'(grant_num), 32'd0);

        // Drain the whole list at two tags per cycle.
        for (int i = 0; i < 32; i++) begin
            drive(2'd2, 2'd0, 7'd0, 7'd0);
            check("drain_count", 32'(free_count), 32'(64 - 2*i));
            check("drain_grant", 32'(grant_num), 32'd2);
            check("drain_valid", 32'(alloc_valid), 32'd3);
            check("drain_tag0", 32'(alloc_tags[6:0]), 32'(32 + 2*i));
            check("drain_tag1", 32'(alloc_tags[13:7]), 32'(33 + 2*i));
            step();
        end
        drive(2'd2, 2'd0, 7'd0, 7'd0);
        check("empty_count", 32'(free_count), 32'd0);
        check("empty_grant", 32'(grant_num), 32'd0);
        check("empty_valid", 32'(alloc_valid), 32'd0);
        check("empty_tags", 32'(alloc_tags), 32'd0);

        // Free into an empty list while dispatching: no same-cycle grant.
        drive(2'd2, 2'd2, 7'd40, 7'd41);
        check("ret_empty_grant", 32'(grant_num), 32'd0);
        check("ret_empty_valid", 32'(alloc_valid), 32'd0);
        step();
        drive(2'd2, 2'd0, 7'd0, 7'd0);
        check("ret_next_count", 32'(free_count), 32'd2);
        check("ret_next_grant", 32'(grant_num), 32'd2);
        check("ret_next_tag0", 32'(alloc_tags[6:0]), 32'd40);
        check("ret_next_tag1", 32'(alloc_tags[13:7]), 32'd41);
        step();

        // One entry held, ask for two while freeing one more.
        drive(2'd0, 2'd1, 7'd60, 7'd0);
        step();
        drive(2'd2, 2'd1, 7'd50, 7'd0);
        check("one_count", 32'(free_count), 32'd1);
        check("one_grant", 32'(grant_num), 32'd1);
        check("one_valid", 32'(alloc_valid), 32'd1);
        check("one_tag0", 32'(alloc_tags[6:0]), 32'd60);
        check("one_tag1", 32'(alloc_tags[13:7]), 32'd0);
        step();
        drive(2'd1, 2'd0, 7'd0, 7'd0);
        check("one_after_count", 32'(free_count), 32'd1);
        check("one_after_tag0", 32'(alloc_tags[6:0]), 32'd50);
        step();
        check("one_final_count", 32'(free_count), 32'd0);
        check("no_overflow_yet", 32'(overflow_err), 32'd0);

        // Overflow boundary: fill to exactly DEPTH, then exceed it.
        reset = 1'b1;
        drive(2'd0, 2'd0, 7'd0, 7'd0);
        step();
        reset = 1'b0;
        drive(2'd1, 2'd0, 7'd0, 7'd0);
        check("ov_tag0", 32'(alloc_tags[6:0]), 32'd32);
        step();
        drive(2'd0, 2'd1, 7'd32, 7'd0);
        check("ov_count63", 32'(free_count), 32'd63);
        step();
        check("ov_full_count", 32'(free_count), 32'd64);
        check("ov_full_noerr", 32'(overflow_err), 32'd0);
        drive(2'd1, 2'd1, 7'd33, 7'd0);
        check("ov_swap_grant", 32'(grant_num), 32'd1);
        check("ov_swap_tag0", 32'(alloc_tags[6:0]), 32'd33);
        step();
        check("ov_swap_noerr", 32'(overflow_err), 32'd0);
        check("ov_swap_count", 32'(free_count), 32'd64);
        drive(2'd0, 2'd1, 7'd5, 7'd0);
        step();
        check("ov_set", 32'(overflow_err), 32'd1);
        drive(2'd2, 2'd0, 7'd0, 7'd0);
        step();
        step();
        check("ov_sticky", 32'(overflow_err), 32'd1);
        reset = 1'b1;
        drive(2'd2, 2'd2, 7'd1, 7'd2);
        step();
        reset = 1'b0;
        drive(2'd0, 2'd0, 7'd0, 7'd0);
        check("ov_cleared", 32'(overflow_err), 32'd0);
        check("rst_wins_count", 32'(free_count), 32'd64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
